// File: rtl/aud_dsp_var.sv
// aud_dsp_var: variable-speed playback engine between the SRAM sample store and the DAC serializer.
// Latency: one output sample per DAC frame. It is registered one cycle after the synchronised
//   falling edge of i_daclrck. A source fetch takes SRAM_LAT+1 cycles.
// Backpressure: none. A tick that lands during a fetch is held pending and serviced on return to RUN.
// Ports: i_clk/i_rst_n are the clock and async active-low reset.
//   i_start/i_pause/i_stop are the control inputs; i_stop has the highest priority.
//   i_speed/i_fast/i_inte select the rate and mode.
//   i_daclrck is the asynchronous DAC frame clock.
//   i_end_addr is the inclusive end of the file. i_sram_data/o_sram_addr form the sample-store port.
//   o_dac_data/o_player_en drive the serializer. o_done pulses at end of file.
// Optional: define AUD_DSP_REVERSE_EN to add i_reverse (backward playback from i_end_addr).
module aud_dsp_var #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 20,
  parameter int SPD_W    = 3,
  parameter int SRAM_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [SPD_W-1:0]  i_speed,
  input  logic              i_fast,
  input  logic              i_inte,
  input  logic              i_daclrck,
`ifdef AUD_DSP_REVERSE_EN
  input  logic              i_reverse,
`endif
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic [DATA_W-1:0] i_sram_data,
  output logic [DATA_W-1:0] o_dac_data,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_player_en,
  output logic              o_done
);

  localparam int FW    = SPD_W + 1;
  localparam int AW1   = ADDR_W + 1;
  localparam int LAT_W = $clog2(SRAM_LAT + 1) + 1;
  localparam int PW    = DATA_W + 1 + SPD_W + 17;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FETCH, S_PAUSE} state_t;

  state_t            state_q;
  logic              lrck_s1_q, lrck_s2_q, lrck_s3_q;
  logic [LAT_W-1:0]  lat_q;
  logic [SPD_W-1:0]  k_q;
  logic [FW-1:0]     f_q;
  logic              fast_q, inte_q, pend_q, pause_req_q;
  logic [DATA_W-1:0] prev_q, cur_q, dac_q;
  logic [ADDR_W-1:0] addr_q;
  logic              en_q, done_q;
  logic              rev_w;

  // Reciprocal table floor(65536/F), built from constants only
  logic [16:0] recip_tab [0:(1<<SPD_W)];
  for (genvar g = 0; g <= (1 << SPD_W); g++) begin : g_recip
    assign recip_tab[g] = 17'(65536 / ((g == 0) ? 1 : g));
  end

  logic              lrck_tick;
  logic [FW-1:0]     k_inc_d;
  logic              skip_d, adv_d, past_end_d;
  logic [AW1-1:0]    step_d, adv_addr_d;
  logic [ADDR_W-1:0] start_addr_d;
  logic [DATA_W-1:0] smp_d;
  logic signed [PW-1:0] diff_x, k_x, rc_x, prev_x, prod_x, interp_x;

  assign lrck_tick = lrck_s3_q & ~lrck_s2_q;

  assign k_inc_d = {1'b0, k_q} + FW'(1);
  // F==1 behaves like fast mode: every tick advances by one source sample
  assign skip_d  = fast_q | (f_q == FW'(1));
  assign adv_d   = skip_d | (k_inc_d == f_q);
  assign step_d  = skip_d ? AW1'(f_q) : AW1'(1);

`ifdef AUD_DSP_REVERSE_EN
  logic rev_q;
  assign rev_w        = rev_q;
  assign start_addr_d = i_reverse ? i_end_addr : '0;
`else
  assign rev_w        = 1'b0;
  assign start_addr_d = '0;
`endif

  // One extra bit so an overrun past i_end_addr (or below 0) is visible, never wrapped
  assign adv_addr_d = rev_w ? ({1'b0, addr_q} - step_d) : ({1'b0, addr_q} + step_d);
  assign past_end_d = rev_w ? adv_addr_d[ADDR_W] : (adv_addr_d > {1'b0, i_end_addr});

  // Linear interpolation: prev + ((cur-prev)*k*RECIP[F]) >>> 16, truncated to DATA_W
  assign diff_x   = {{(PW-DATA_W){cur_q[DATA_W-1]}}, cur_q} - {{(PW-DATA_W){prev_q[DATA_W-1]}}, prev_q};
  assign prev_x   = {{(PW-DATA_W){prev_q[DATA_W-1]}}, prev_q};
  assign k_x      = PW'(k_q);
  assign rc_x     = PW'(recip_tab[f_q]);
  assign prod_x   = diff_x * k_x * rc_x;
  assign interp_x = prev_x + (prod_x >>> 16);
  assign smp_d    = (!skip_d && inte_q) ? interp_x[DATA_W-1:0] : cur_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      lrck_s1_q <= 1'b0; lrck_s2_q <= 1'b0; lrck_s3_q <= 1'b0;
      lat_q <= '0; k_q <= '0; f_q <= FW'(1);
      fast_q <= 1'b0; inte_q <= 1'b0; pend_q <= 1'b0; pause_req_q <= 1'b0;
      prev_q <= '0; cur_q <= '0; dac_q <= '0; addr_q <= '0;
      en_q <= 1'b0; done_q <= 1'b0;
`ifdef AUD_DSP_REVERSE_EN
      rev_q <= 1'b0;
`endif
    end else begin
      lrck_s1_q <= i_daclrck;
      lrck_s2_q <= lrck_s1_q;
      lrck_s3_q <= lrck_s2_q;
      done_q    <= 1'b0;
      if (state_q != S_IDLE && i_stop) begin
        state_q <= S_IDLE;
        en_q <= 1'b0; dac_q <= '0; addr_q <= '0;
        pend_q <= 1'b0; pause_req_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            en_q <= 1'b0; dac_q <= '0; addr_q <= '0;
            pend_q <= 1'b0; pause_req_q <= 1'b0;
            if (i_start) begin
              state_q <= S_LOAD;
              lat_q   <= '0;
              addr_q  <= start_addr_d;
`ifdef AUD_DSP_REVERSE_EN
              rev_q   <= i_reverse;
`endif
            end
          end
          S_LOAD, S_FETCH: begin
            // A pause request is remembered so the fetch always completes first
            if (i_pause) pause_req_q <= 1'b1;
            if (state_q == S_FETCH && lrck_tick) pend_q <= 1'b1;
            if (lat_q == LAT_W'(SRAM_LAT)) begin
              cur_q  <= i_sram_data;
              f_q    <= {1'b0, i_speed} + FW'(1);
              fast_q <= i_fast;
              inte_q <= i_inte;
`ifdef AUD_DSP_REVERSE_EN
              rev_q  <= i_reverse;
`endif
              if (state_q == S_LOAD) begin
                prev_q <= '0;
                k_q    <= '0;
              end
              pause_req_q <= 1'b0;
              if (pause_req_q || i_pause) begin
                state_q <= S_PAUSE;
                en_q    <= 1'b0;
                pend_q  <= 1'b0;
              end else begin
                state_q <= S_RUN;
                en_q    <= 1'b1;
              end
            end else begin
              lat_q <= lat_q + LAT_W'(1);
            end
          end
          S_RUN: begin
            if (i_pause) begin
              state_q <= S_PAUSE;
              en_q    <= 1'b0;
            end else if (lrck_tick || pend_q) begin
              pend_q <= 1'b0;
              dac_q  <= smp_d;
              if (adv_d) begin
                k_q <= '0;
                if (!skip_d && inte_q) prev_q <= cur_q;
                if (past_end_d) begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b1;
                  en_q    <= 1'b0;
                  addr_q  <= '0;
                end else begin
                  state_q <= S_FETCH;
                  addr_q  <= adv_addr_d[ADDR_W-1:0];
                  lat_q   <= '0;
                end
              end else begin
                k_q <= k_inc_d[SPD_W-1:0];
              end
            end
          end
          S_PAUSE: begin
            if (!i_pause && i_start) begin
              state_q <= S_RUN;
              en_q    <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign o_dac_data  = dac_q;
  assign o_sram_addr = addr_q;
  assign o_player_en = en_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_aud_dsp_var.sv
// tb_aud_dsp_var: table-driven vectors plus hand sequences for pause/stop, pending tick and async reset.
// Timing: a DAC frame is 8 cycles high then low. The sample is taken 3 edges after the fall.
// SRAM model: registered read with one cycle of latency.
module tb_aud_dsp_var;
  localparam int DATA_W = 16, ADDR_W = 20, SPD_W = 3;

  logic clk = 1'b0, clk_en = 1'b1;
  logic i_rst_n, i_start, i_pause, i_stop, i_fast, i_inte, i_daclrck;
  logic [SPD_W-1:0]  i_speed;
  logic [ADDR_W-1:0] i_end_addr;
  logic [DATA_W-1:0] i_sram_data;
  logic [DATA_W-1:0] o_dac_data;
  logic [ADDR_W-1:0] o_sram_addr;
  logic o_player_en, o_done;

  aud_dsp_var #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SPD_W(SPD_W), .SRAM_LAT(1)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_pause(i_pause), .i_stop(i_stop),
    .i_speed(i_speed), .i_fast(i_fast), .i_inte(i_inte), .i_daclrck(i_daclrck),
    .i_end_addr(i_end_addr), .i_sram_data(i_sram_data), .o_dac_data(o_dac_data),
    .o_sram_addr(o_sram_addr), .o_player_en(o_player_en), .o_done(o_done));

  always #5 if (clk_en) clk = ~clk;

  logic [DATA_W-1:0] mem [0:63];
  always @(posedge clk) i_sram_data <= mem[o_sram_addr[5:0]];

  int checks = 0, failures = 0, done_cnt = 0;
  int exp_q[$];
  always @(negedge clk) if (o_done) done_cnt++;

  typedef struct {
    int mode; int speed; bit fast; bit inte; int end_addr; int n; int exp[8]; bit done_last;
  } vec_t;
  vec_t vt [5];

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_mem(input int mode);
    for (int a = 0; a < 64; a++) begin
      case (mode)
        0:       mem[a] = DATA_W'(a);
        default: mem[a] = DATA_W'((a + 1) * 400);
      endcase
    end
    if (mode == 2) begin
      mem[0] = DATA_W'(-400);
      mem[1] = DATA_W'(400);
    end
  endtask

  task automatic pop_cmp(input string nm);
    int e;
    if (exp_q.size() == 0) begin
      chk({nm, "_sb_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk(nm, int'($signed(o_dac_data)), e);
    end
  endtask

  // One DAC frame. The expected sample is queued before the falling edge is driven.
  task automatic frame(input string nm, input int expv, input bit exp_done);
    exp_q.push_back(expv);
    i_daclrck = 1'b1; cyc(8);
    i_daclrck = 1'b0; cyc(3);
    pop_cmp(nm);
    chk({nm, "_done"}, int'(o_done), int'(exp_done));
    cyc(8);
  endtask

  task automatic start_play(input int mode, input int spd, input bit fast, input bit inte, input int ea);
    load_mem(mode);
    i_speed = SPD_W'(spd); i_fast = fast; i_inte = inte; i_end_addr = ADDR_W'(ea);
    i_start = 1'b1; cyc(1); i_start = 1'b0; cyc(4);
  endtask

  task automatic stop_play();
    i_stop = 1'b1; cyc(1); i_stop = 1'b0; cyc(2);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_en"},   int'(o_player_en), 0);
    chk({nm, "_addr"}, int'(o_sram_addr), 0);
    chk({nm, "_dac"},  int'(o_dac_data),  0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int d0;
    vt[0].mode = 0; vt[0].speed = 0; vt[0].fast = 0; vt[0].inte = 0; vt[0].end_addr = 3;
    vt[0].n = 4; vt[0].exp = '{0, 1, 2, 3, 0, 0, 0, 0}; vt[0].done_last = 1;
    vt[1].mode = 0; vt[1].speed = 2; vt[1].fast = 1; vt[1].inte = 0; vt[1].end_addr = 10;
    vt[1].n = 4; vt[1].exp = '{0, 3, 6, 9, 0, 0, 0, 0}; vt[1].done_last = 1;
    vt[2].mode = 1; vt[2].speed = 3; vt[2].fast = 0; vt[2].inte = 0; vt[2].end_addr = 10;
    vt[2].n = 8; vt[2].exp = '{400, 400, 400, 400, 800, 800, 800, 800}; vt[2].done_last = 0;
    vt[3].mode = 1; vt[3].speed = 3; vt[3].fast = 0; vt[3].inte = 1; vt[3].end_addr = 10;
    vt[3].n = 8; vt[3].exp = '{0, 100, 200, 300, 400, 500, 600, 700}; vt[3].done_last = 0;
    vt[4].mode = 2; vt[4].speed = 3; vt[4].fast = 0; vt[4].inte = 1; vt[4].end_addr = 10;
    vt[4].n = 8; vt[4].exp = '{0, -100, -200, -300, -400, -200, 0, 200}; vt[4].done_last = 0;

    i_rst_n = 1'b0; i_start = 0; i_pause = 0; i_stop = 0; i_fast = 0; i_inte = 0;
    i_daclrck = 1'b1; i_speed = '0; i_end_addr = '0;
    load_mem(0);
    cyc(4);
    chk_idle("reset");
    chk("reset_done", int'(o_done), 0);
    i_rst_n = 1'b1; cyc(2);

    for (int v = 0; v < 5; v++) begin
      d0 = done_cnt;
      start_play(vt[v].mode, vt[v].speed, vt[v].fast, vt[v].inte, vt[v].end_addr);
      for (int i = 0; i < vt[v].n; i++)
        frame($sformatf("v%0d_s%0d", v, i), vt[v].exp[i], vt[v].done_last && (i == vt[v].n - 1));
      if (vt[v].done_last) begin
        chk_idle($sformatf("v%0d_end", v));
        chk($sformatf("v%0d_done_pulses", v), done_cnt - d0, 1);
      end else begin
        stop_play();
        chk_idle($sformatf("v%0d_stop", v));
        chk($sformatf("v%0d_no_done", v), done_cnt - d0, 0);
      end
    end

    // Pause after the 5th sample, hold across 10 frames, resume, then stop+pause together
    d0 = done_cnt;
    start_play(0, 0, 0, 0, 20);
    for (int i = 0; i < 5; i++) frame($sformatf("pz_s%0d", i), i, 0);
    i_pause = 1'b1; cyc(1); i_pause = 1'b0; cyc(2);
    chk("pz_en", int'(o_player_en), 0);
    for (int i = 0; i < 10; i++) frame($sformatf("pz_hold%0d", i), 4, 0);
    chk("pz_addr", int'(o_sram_addr), 5);
    chk("pz_en_hold", int'(o_player_en), 0);
    i_start = 1'b1; cyc(1); i_start = 1'b0; cyc(1);
    chk("pz_resume_en", int'(o_player_en), 1);
    frame("pz_s5", 5, 0);
    i_stop = 1'b1; i_pause = 1'b1; cyc(1); i_stop = 1'b0; i_pause = 1'b0; cyc(2);
    chk_idle("pz_stop");
    chk("pz_no_done", done_cnt - d0, 0);

    // Second falling edge lands while the first advance is still fetching
    start_play(0, 0, 0, 0, 20);
    frame("pend_s0", 0, 0);
    i_daclrck = 1'b1; cyc(8);
    exp_q.push_back(1);
    i_daclrck = 1'b0; cyc(1);
    i_daclrck = 1'b1; cyc(1);
    exp_q.push_back(2);
    i_daclrck = 1'b0; cyc(1);
    pop_cmp("pend_s1");
    cyc(3);
    pop_cmp("pend_s2");
    cyc(10);
    chk("pend_settled", int'(o_dac_data), 2);
    stop_play();

    // Async reset while fetching with the clock stopped
    start_play(1, 0, 0, 0, 20);
    frame("ar_s0", 400, 0);
    i_daclrck = 1'b1; cyc(8);
    i_daclrck = 1'b0;
    repeat (3) @(posedge clk);
    clk_en = 1'b0;
    #2;
    chk("ar_pre_dac", int'(o_dac_data), 800);
    chk("ar_pre_en", int'(o_player_en), 1);
    i_rst_n = 1'b0;
    #1;
    chk_idle("ar_async");
    chk("ar_async_done", int'(o_done), 0);
    #5 i_rst_n = 1'b1;
    #5 clk_en = 1'b1;
    cyc(3);
    start_play(1, 0, 0, 0, 20);
    frame("ar_replay0", 400, 0);
    frame("ar_replay1", 800, 0);
    stop_play();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aud_dsp_var.md
Name: aud_dsp_var

Overview:
Variable-speed audio playback engine between the SRAM sample store and the AudPlayer/WM8731 DAC serializer.
- Fetches signed PCM samples from SRAM and produces one output sample per DAC left/right frame.
- Supports fast playback (sample skipping) and slow playback with 0th-order (hold) or 1st-order (linear) interpolation.
- Generalises the first-generation DSP in sample width, address width and speed range, and adds end-of-file detection and pause/resume.

Parameters:
DATA_W, 16, sample width (signed two's complement)
ADDR_W, 20, SRAM address width
SPD_W, 3, speed code width; factor F = i_speed+1, range 1..2^SPD_W
SRAM_LAT, 1, cycles from o_sram_addr change to valid i_sram_data

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous, active-low
i_start  in  1  start from IDLE, or resume from PAUSE (level, sampled each cycle)
i_pause  in  1  pause
i_stop  in  1  stop; return to IDLE
i_speed  in  SPD_W  speed code; F = i_speed+1
i_fast  in  1  1 = fast (skip), 0 = slow (stretch)
i_inte  in  1  slow mode only: 1 = linear interpolation, 0 = hold
i_daclrck  in  1  DAC LR clock, asynchronous to i_clk
i_end_addr  in  ADDR_W  last valid sample address (inclusive)
i_sram_data  in  DATA_W  SRAM read data
o_dac_data  out  DATA_W  sample to AudPlayer
o_sram_addr  out  ADDR_W  SRAM read address
o_player_en  out  1  enables AudPlayer
o_done  out  1  one-cycle pulse when end of file is reached

Behaviour:
- Reset values: o_dac_data=0, o_sram_addr=0, o_player_en=0, o_done=0; state IDLE; phase k=0; prev=0; cur=0.
- Tick generation: i_daclrck passes through a 2-FF synchroniser; a falling edge of the synchronised signal produces a one-cycle tick.
- States: IDLE, LOAD, RUN, FETCH, PAUSE.
- IDLE:
  - o_player_en=0, address 0, o_dac_data=0.
  - i_start -> LOAD.
- LOAD:
  - Drive address 0 and wait SRAM_LAT cycles.
  - Capture cur=mem[0], prev=0, k=0.
  - Latch F, fast and inte -> RUN.
- RUN: o_player_en=1. On each tick, o_dac_data is registered on the following cycle:
  - Fast, or F==1: out=cur; next address = addr+F.
  - Slow, hold: out=cur; k++; when k==F: k=0, next address = addr+1.
  - Slow, linear: out = prev + ((cur-prev)*k*RECIP[F]) >>> 16.
    - RECIP[F] = floor(65536/F); RECIP[1] is unused because k is always 0 when F=1.
    - The product is a full-width signed intermediate (DATA_W+1 + SPD_W + 17 bits); the result is truncated to DATA_W.
    - k++; when k==F: k=0, prev<=cur, next address = addr+1.
- Address advance: when an advance occurs, the next address is computed in ADDR_W+1 bits, with no wrap.
  - If it exceeds i_end_addr: -> IDLE, o_done=1 for one cycle, o_player_en=0, o_dac_data=0 on the next cycle, address 0.
  - Otherwise -> FETCH.
- FETCH:
  - Drive the new address and wait SRAM_LAT cycles.
  - Capture cur, re-latch F/fast/inte -> RUN.
  - A tick arriving during FETCH is held pending and serviced on return to RUN, so no tick is lost.
- Parameter changes: speed and mode changes take effect only at LOAD/FETCH (source-sample boundaries), never mid-segment.
- PAUSE:
  - o_player_en=0; o_dac_data, address, k, prev and cur are held.
  - i_start -> RUN, resuming at the same phase.
- Control priority, every cycle, in any non-IDLE state: i_stop > i_pause > i_start.
  - i_stop -> IDLE: outputs and address cleared, o_done not asserted.
  - i_pause entered from FETCH completes the fetch first.
- i_start while already in RUN is ignored.
- i_end_addr=0: a single-sample file; the first advance terminates playback.
- Reset asserted mid-playback: all registers return to their reset values immediately, regardless of i_clk.

Optional Feature:
Macro AUD_DSP_REVERSE_EN.
- Defined:
  - Adds port i_reverse (in, 1). i_reverse is latched at LOAD/FETCH.
  - When set, advances subtract instead of add (addr-F or addr-1). Computing the next address below 0 ends playback (IDLE plus o_done).
  - LOAD starts at i_end_addr instead of 0.
- Undefined: the port is absent and playback is forward-only.

Test Plan:
- Normal: mem[a]=a, i_speed=0, i_end_addr=3, i_start -> on successive ticks o_dac_data=0,1,2,3; o_done pulses after the 4th sample; o_player_en falls; address 0.
- Fast: mem[a]=a, i_fast=1, i_speed=2 (F=3), i_end_addr=10 -> outputs 0,3,6,9 then o_done.
- Slow hold: mem[a]=(a+1)*400, i_fast=0, i_inte=0, i_speed=3 (F=4) -> 400 ×4, then 800 ×4.
- Slow linear: same memory and F=4, i_inte=1 -> 0,100,200,300,400,500,600,700; mem[0]=-400, mem[1]=400 -> 0,-100,-200,-300,-400,-200,0,200.
- Pause/stop: pause after the 5th sample -> o_player_en=0, o_dac_data held, no address change across 10 ticks; i_start resumes with the 6th correct sample; i_stop asserted together with i_pause -> IDLE, no o_done.
- Async reset mid-FETCH with i_clk stopped -> all outputs 0 immediately; a subsequent i_start replays from address 0.
